// File: rtl/flag_fifo_pkg.sv
// Shared constants and helpers for the flag FIFO and its storage.
package flag_fifo_pkg;

  localparam bit FIFO_SHOWAHEAD = 1'b1;
  localparam bit FIFO_NORMAL    = 1'b0;

  function automatic int unsigned fifo_depth(input int unsigned widthu);
    return 32'd1 << widthu;
  endfunction

endpackage

// File: rtl/flag_fifo_if.sv
// Producer/consumer-facing bundle of the flag FIFO; master drives requests, slave is the FIFO.
interface flag_fifo_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WIDTHU = 4
);

  logic              sclr;
  logic              err_clr;
  logic              wrreq;
  logic [WIDTH-1:0]  data;
  logic              rdreq;
  logic [WIDTH-1:0]  q;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [WIDTHU:0]   usedw;
  logic              overflow;
  logic              underflow;

  modport master (
    output sclr, err_clr, wrreq, data, rdreq,
    input  q, empty, full, almost_full, almost_empty, usedw, overflow, underflow
  );

  modport slave (
    input  sclr, err_clr, wrreq, data, rdreq,
    output q, empty, full, almost_full, almost_empty, usedw, overflow, underflow
  );

endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, read port asynchronous (show-ahead) or registered.
module fifo_sdp_ram
  import flag_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned WIDTHU    = 4,
  parameter bit          SHOWAHEAD = FIFO_SHOWAHEAD
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [WIDTHU-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic              rclr_i,
  input  logic [WIDTHU-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int unsigned DEPTH = fifo_depth(WIDTHU);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (SHOWAHEAD == FIFO_NORMAL) begin : g_reg
    logic [WIDTH-1:0] rdata_q;

    // Output register is cleared with the FIFO; the array itself is not.
    always_ff @(posedge clk_i) begin
      if (rclr_i) begin
        rdata_q <= '0;
      end else if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end

    assign rdata_o = rdata_q;
  end else begin : g_async
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = re_i ^ rclr_i;
    assign rdata_o        = mem_q[raddr_i];
  end

endmodule

// File: rtl/flag_fifo.sv
// Single-clock FIFO with occupancy count, almost flags and sticky overflow/underflow errors.
module flag_fifo
  import flag_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned WIDTHU    = 4,
  parameter int unsigned AF_LEVEL  = fifo_depth(WIDTHU) - 1,
  parameter int unsigned AE_LEVEL  = 1,
  parameter bit          SHOWAHEAD = FIFO_SHOWAHEAD
) (
  input logic        clk,
  input logic        rst_n,
  flag_fifo_if.slave bus
);

  localparam int unsigned DEPTH = fifo_depth(WIDTHU);
  localparam logic [WIDTHU:0] DepthCnt = (WIDTHU + 1)'(DEPTH);
  localparam logic [WIDTHU:0] AfCnt    = (WIDTHU + 1)'(AF_LEVEL);
  localparam logic [WIDTHU:0] AeCnt    = (WIDTHU + 1)'(AE_LEVEL);

  logic [WIDTHU-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTHU-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTHU:0]   usedw_q, usedw_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_ok, wr_ok, clr;

  assign clr   = ~rst_n | bus.sclr;
  assign rd_ok = bus.rdreq & ~empty_q;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_ok = bus.wrreq & (~full_q | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_ok && !rd_ok) begin
        usedw_d = usedw_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        usedw_d = usedw_q - 1'b1;
      end
      if (bus.err_clr) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      // Set events are applied after the clear so they win a same-cycle err_clr.
      if (bus.wrreq && !wr_ok) ovf_d = 1'b1;
      if (bus.rdreq && empty_q && !bus.wrreq) unf_d = 1'b1;
    end
    empty_d  = (usedw_d == '0);
    full_d   = (usedw_d == DepthCnt);
    afull_d  = (usedw_d >= AfCnt);
    aempty_d = (usedw_d <= AeCnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_sdp_ram #(
    .WIDTH    (WIDTH),
    .WIDTHU   (WIDTHU),
    .SHOWAHEAD(SHOWAHEAD)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_ok & ~clr),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.data),
    .re_i   (rd_ok & ~clr),
    .rclr_i (clr),
    .raddr_i(rd_ptr_q),
    .rdata_o(bus.q)
  );

  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.usedw        = usedw_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_flag_fifo.sv
// Bench for flag_fifo: show-ahead and registered instances share stimulus and a queue model.
module tb_flag_fifo;

  localparam int unsigned W     = 8;
  localparam int unsigned WU    = 2;
  localparam int          DEPTH = 4;
  localparam int          AF    = 3;
  localparam int          AE    = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flag_fifo_if #(.WIDTH(W), .WIDTHU(WU)) bus_sa ();
  flag_fifo_if #(.WIDTH(W), .WIDTHU(WU)) bus_rg ();

  flag_fifo #(
    .WIDTH(W), .WIDTHU(WU), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(1'b1)
  ) dut_sa (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_sa.slave)
  );

  flag_fifo #(
    .WIDTH(W), .WIDTHU(WU), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(1'b0)
  ) dut_rg (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_rg.slave)
  );

  typedef struct {
    int         usedw;
    bit         empty, full, af, ae, ovf, unf;
    bit         q_valid;
    logic [7:0] q_sa;
    logic [7:0] q_rg;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_q[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_qreg;
  int         n_cmp = 0;
  int         n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // One clock of stimulus; the reference model predicts the state after the next edge.
  task automatic cycle(input bit rst, input bit sclr, input bit eclr, input bit wr,
                       input logic [7:0] d, input bit rd);
    exp_t e;
    bit   was_empty, was_full, rd_ok, wr_ok;
    @(negedge clk);
    #1;
    rst_n = rst;
    bus_sa.sclr = sclr; bus_sa.err_clr = eclr; bus_sa.wrreq = wr;
    bus_sa.data = d;    bus_sa.rdreq = rd;
    bus_rg.sclr = sclr; bus_rg.err_clr = eclr; bus_rg.wrreq = wr;
    bus_rg.data = d;    bus_rg.rdreq = rd;
    if (!rst || sclr) begin
      model_q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_qreg = 8'h00;
    end else begin
      was_empty = (model_q.size() == 0);
      was_full  = (model_q.size() == DEPTH);
      rd_ok     = rd && !was_empty;
      wr_ok     = wr && (!was_full || rd_ok);
      if (rd_ok) m_qreg = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
      m_ovf = (wr && !wr_ok) || (m_ovf && !eclr);
      m_unf = (rd && was_empty && !wr) || (m_unf && !eclr);
    end
    e.usedw   = model_q.size();
    e.empty   = (model_q.size() == 0);
    e.full    = (model_q.size() == DEPTH);
    e.af      = (model_q.size() >= AF);
    e.ae      = (model_q.size() <= AE);
    e.ovf     = m_ovf;
    e.unf     = m_unf;
    e.q_valid = (model_q.size() != 0);
    e.q_sa    = e.q_valid ? model_q[0] : 8'h00;
    e.q_rg    = m_qreg;
    sb.push_back(e);
  endtask

  task automatic idle();            cycle(1, 0, 0, 0, 8'h00, 0); endtask
  task automatic wr(input logic [7:0] d); cycle(1, 0, 0, 1, d, 0); endtask
  task automatic rd();              cycle(1, 0, 0, 0, 8'h00, 1); endtask
  task automatic wrd(input logic [7:0] d); cycle(1, 0, 0, 1, d, 1); endtask
  task automatic settle();          @(posedge clk); #2; endtask

  // Monitor: every edge that has a prediction pending is compared on both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sa.usedw", 32'(bus_sa.usedw), 32'(e.usedw));
        check("sa.empty", 32'(bus_sa.empty), 32'(e.empty));
        check("sa.full", 32'(bus_sa.full), 32'(e.full));
        check("sa.almost_full", 32'(bus_sa.almost_full), 32'(e.af));
        check("sa.almost_empty", 32'(bus_sa.almost_empty), 32'(e.ae));
        check("sa.overflow", 32'(bus_sa.overflow), 32'(e.ovf));
        check("sa.underflow", 32'(bus_sa.underflow), 32'(e.unf));
        if (e.q_valid) check("sa.q", 32'(bus_sa.q), 32'(e.q_sa));
        check("rg.usedw", 32'(bus_rg.usedw), 32'(e.usedw));
        check("rg.empty", 32'(bus_rg.empty), 32'(e.empty));
        check("rg.full", 32'(bus_rg.full), 32'(e.full));
        check("rg.almost_full", 32'(bus_rg.almost_full), 32'(e.af));
        check("rg.almost_empty", 32'(bus_rg.almost_empty), 32'(e.ae));
        check("rg.overflow", 32'(bus_rg.overflow), 32'(e.ovf));
        check("rg.underflow", 32'(bus_rg.underflow), 32'(e.unf));
        check("rg.q", 32'(bus_rg.q), 32'(e.q_rg));
      end
    end
  end

  initial begin
    int pw, pr;
    bus_sa.sclr = 0; bus_sa.err_clr = 0; bus_sa.wrreq = 0; bus_sa.data = 0; bus_sa.rdreq = 0;
    bus_rg.sclr = 0; bus_rg.err_clr = 0; bus_rg.wrreq = 0; bus_rg.data = 0; bus_rg.rdreq = 0;
    cycle(0, 0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 0, 8'h00, 0);
    settle();
    check("reset.empty", 32'(bus_sa.empty), 1);
    check("reset.almost_empty", 32'(bus_sa.almost_empty), 1);
    check("reset.rg_q", 32'(bus_rg.q), 0);

    // Fill, then one write too many.
    for (int i = 0; i < 4; i++) wr(8'hA1 + 8'(i));
    wr(8'hA5);
    settle();
    check("fill.usedw", 32'(bus_sa.usedw), 4);
    check("fill.overflow", 32'(bus_sa.overflow), 1);
    check("fill.q", 32'(bus_sa.q), 32'h A1);

    // Drain, read past empty, clear errors.
    for (int i = 0; i < 4; i++) rd();
    rd();
    settle();
    check("drain.empty", 32'(bus_sa.empty), 1);
    check("drain.underflow", 32'(bus_sa.underflow), 1);
    check("drain.rg_q", 32'(bus_rg.q), 32'h A4);
    cycle(1, 0, 1, 0, 8'h00, 0);
    settle();
    check("errclr.underflow", 32'(bus_sa.underflow), 0);

    // Simultaneous read+write on full and on empty.
    for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i));
    wrd(8'hB0);
    settle();
    check("simfull.usedw", 32'(bus_sa.usedw), 4);
    check("simfull.overflow", 32'(bus_sa.overflow), 0);
    for (int i = 0; i < 4; i++) rd();
    settle();
    check("simfull.b0_4th", 32'(bus_rg.q), 32'h B0);
    wrd(8'hC0);
    settle();
    check("simempty.usedw", 32'(bus_sa.usedw), 1);
    check("simempty.underflow", 32'(bus_sa.underflow), 0);
    check("simempty.q", 32'(bus_sa.q), 32'h C0);
    rd();

    // Pointer wrap with usedw oscillating 0..3; order must be 0x00..0x0B.
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 3; k++) wr(8'(g * 3 + k));
      for (int k = 0; k < 3; k++) begin
        settle();
        check("wrap.order", 32'(bus_sa.q), 32'(g * 3 + k));
        rd();
      end
    end

    // Registered output: load, hold, rejected read.
    wr(8'h55);
    rd();
    settle();
    check("reg.q", 32'(bus_rg.q), 32'h55);
    idle(); idle(); idle();
    settle();
    check("reg.hold", 32'(bus_rg.q), 32'h55);
    rd();
    settle();
    check("reg.rejected", 32'(bus_rg.q), 32'h55);
    check("reg.underflow", 32'(bus_rg.underflow), 1);

    // sclr and then reset, each with a concurrent write, from usedw=3 with overflow set.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) wr(8'h70 + 8'(i));
      rd();
      settle();
      check("clr.pre_usedw", 32'(bus_sa.usedw), 3);
      if (pass == 0) cycle(1, 1, 0, 1, 8'hEE, 0);
      else           cycle(0, 0, 0, 1, 8'hEE, 0);
      settle();
      check("clr.usedw", 32'(bus_sa.usedw), 0);
      check("clr.empty", 32'(bus_sa.empty), 1);
      check("clr.overflow", 32'(bus_sa.overflow), 0);
      check("clr.rg_q", 32'(bus_rg.q), 0);
    end

    // Randomised traffic in phases of differing fill/drain bias.
    for (int ph = 0; ph < 30; ph++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        cycle($urandom_range(0, 199) != 0, $urandom_range(0, 99) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 99) < pw,
              8'($urandom_range(0, 255)), $urandom_range(0, 99) < pr);
      end
    end

    settle();
    settle();
    check("scoreboard.drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_fifo.md
Name: flag_fifo

Overview:
Single-clock parametrised FIFO. It is the successor to the team's basic FIFO and is used for CPU/IO buffering, e.g. PIO, sound and DMA data paths.
- Adds an unambiguous occupancy count, almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Output mode is selectable: show-ahead or registered.
- Sits between a producer and a consumer in one clock domain; storage is an inferred simple dual-port RAM.

Parameters:
WIDTH, 8, data width in bits (>=1)
WIDTHU, 4, address width; DEPTH = 2**WIDTHU entries (WIDTHU>=1)
AF_LEVEL, 2**WIDTHU-1, almost_full asserts when usedw >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when usedw <= AE_LEVEL (0..DEPTH-1)
SHOWAHEAD, 1, 1 = q presents head entry combinationally; 0 = q registered, updated on read

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
sclr  in  1  synchronous clear of pointers, count and error flags
err_clr  in  1  clears overflow/underflow only
wrreq  in  1  write request
data  in  WIDTH  write data
rdreq  in  1  read request (ack in show-ahead mode)
q  out  WIDTH  read data
empty  out  1  usedw == 0
full  out  1  usedw == DEPTH
almost_full  out  1  usedw >= AF_LEVEL
almost_empty  out  1  usedw <= AE_LEVEL
usedw  out  WIDTHU+1  occupancy, 0..DEPTH
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was made while empty

Behaviour:
- Priority: rst_n low > sclr > normal operation. sclr and rst_n do not clear the RAM contents.
- Reset/sclr values:
  - rd_ptr = wr_ptr = 0, usedw = 0.
  - empty = 1, full = 0.
  - almost_empty = 1; almost_full = 0.
  - overflow = underflow = 0.
  - q = 0 when SHOWAHEAD = 0.
- Accept rules, evaluated on the current registered state:
  - rd_ok = rdreq & ~empty.
  - wr_ok = wrreq & (~full | rd_ok), so a full FIFO accepts a write in the same cycle as a read.
- Pointers advance by 1 modulo DEPTH on rd_ok / wr_ok and wrap naturally.
- On wr_ok, mem[wr_ptr] <= data.
- usedw update: +1 if wr_ok & ~rd_ok; -1 if rd_ok & ~wr_ok; unchanged otherwise.
- Empty with rdreq & wrreq: the write is accepted, the read is ignored, usedw becomes 1, and underflow is not set.
- All flags (empty, full, almost_*) are registered and derived from the next-state usedw, so they are valid in the same cycle as usedw, with no extra lag.
- overflow is set when wrreq & ~wr_ok. underflow is set when rdreq & empty & ~wrreq. Both hold until err_clr, sclr or reset; a set event in the same cycle as err_clr wins.
- SHOWAHEAD = 1:
  - q = mem[rd_ptr]; q is don't-care while empty.
  - There is no write-to-read bypass. A word written into an empty FIFO appears on q in the cycle empty deasserts (1 cycle after the write).
- SHOWAHEAD = 0:
  - On rd_ok, q <= mem[rd_ptr], so data is valid 1 cycle after rdreq.
  - q holds its value otherwise, including on a rejected read.
- Reset or sclr in mid-operation takes effect at the next edge and discards all other requests in that cycle.

Decomposition:
- Shared package/include: mode constants FIFO_SHOWAHEAD = 1 and FIFO_NORMAL = 0, and a depth helper function (2**WIDTHU).
- One sub-module, fifo_sdp_ram: WIDTH x DEPTH simple dual-port RAM with a synchronous write port and a read port that is asynchronous or registered per mode.
- Pointer, count and flag logic stays in flag_fifo.

Test Plan:
All scenarios use WIDTH=8, WIDTHU=2 (DEPTH 4), AF_LEVEL=3, AE_LEVEL=1, SHOWAHEAD=1 unless stated.
1. Fill: write 0xA1..0xA4 on back-to-back cycles -> usedw 1,2,3,4. almost_empty drops after the 2nd write, almost_full rises after the 3rd, full rises after the 4th. A 5th write -> overflow=1, usedw stays 4.
2. Drain: from full, q=0xA1. Assert rdreq for 4 cycles -> q steps 0xA2, 0xA3, 0xA4, then empty=1. A further rdreq -> underflow=1; err_clr -> underflow=0.
3. Simultaneous ops: with full, rdreq+wrreq(0xB0) -> usedw stays 4, no overflow, 0xB0 is read out 4th. With empty, rdreq+wrreq(0xC0) -> usedw=1, no underflow, q=0xC0 the next cycle.
4. Wrap: 12 interleaved writes of 0x00..0x0B and reads with usedw oscillating 0..3 -> pointers wrap 3 times and the read order is exactly 0x00..0x0B.
5. SHOWAHEAD=0: write 0x55, then rdreq -> q=0x55 one cycle later and held through 3 idle cycles. rdreq while empty -> q unchanged, underflow=1.
6. Clear: usedw=3 with overflow=1, then sclr together with wrreq -> next cycle usedw=0, empty=1, overflow=0, write dropped. Repeat with rst_n=0 -> same result.
